// File: rtl/lsu_pkg.sv
// Load/store unit shared types: access sizes, FSM states,
// RAM geometry and the alignment rule.
package lsu_pkg;

  localparam int RAM_AW   = 8;
  localparam int OFFSET_W = 3;
  localparam int LADDR_W  = RAM_AW + OFFSET_W;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_e;

  function automatic logic misaligned(
    size_e s,
    logic [OFFSET_W-1:0] off
  );
    logic m;
    unique case (s)
      SZ_B: m = 1'b0;
      SZ_H: m = off[0];
      SZ_W: m = |off[1:0];
      SZ_D: m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bundle between the pipeline and the
// load/store unit.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;

  modport master (
    output req_valid, req_write, req_addr,
    output req_size, req_signed, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_misaligned
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_size, req_signed, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_misaligned
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extract with sign extension and
// store merge into a captured doubleword.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e               size_i,
  input  logic                sgn_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [63:0]         rdata_i,
  input  logic [63:0]         old_i,
  input  logic [63:0]         wdata_i,
  output logic [63:0]         load_o,
  output logic [63:0]         merge_o
);

  logic [5:0]  sa;
  logic [63:0] sh;
  logic [63:0] msk;
  logic [63:0] msk_sh;

  assign sa = {offset_i, 3'b000};
  assign sh = rdata_i >> sa;

  always_comb begin
    load_o = sh;
    msk    = '1;
    unique case (size_i)
      SZ_B: begin
        load_o = {{56{sgn_i & sh[7]}}, sh[7:0]};
        msk    = 64'h0000_0000_0000_00ff;
      end
      SZ_H: begin
        load_o = {{48{sgn_i & sh[15]}}, sh[15:0]};
        msk    = 64'h0000_0000_0000_ffff;
      end
      SZ_W: begin
        load_o = {{32{sgn_i & sh[31]}}, sh[31:0]};
        msk    = 64'h0000_0000_ffff_ffff;
      end
      SZ_D: begin
        load_o = sh;
        msk    = '1;
      end
    endcase
  end

  assign msk_sh  = msk << sa;
  assign merge_o = (old_i & ~msk_sh)
                 | ((wdata_i << sa) & msk_sh);

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of a 256x64 RAM
// that writes on the falling clock edge.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  lsu_if.slave              bus,
  output logic [RAM_AW-1:0] ram_address,
  output logic [63:0]       ram_in,
  output logic              ram_write,
  input  logic [63:0]       ram_out
);

  state_e state_q, state_d;

  logic               write_q;
  size_e              size_q;
  logic               signed_q;
  logic [LADDR_W-1:0] addr_q;
  logic [63:0]        wdata_q;
  logic [63:0]        cap_q;
  logic [63:0]        rdata_q;
  logic               mis_q;

  logic        accept;
  logic        mis_req;
  logic [63:0] load_val;
  logic [63:0] merged;
  logic        unused_addr;

  // Bits above the RAM window alias by design.
  assign unused_addr = ^bus.req_addr[63:LADDR_W];

  assign accept  = bus.req_valid && (state_q == S_IDLE);
  assign mis_req = misaligned(
    size_e'(bus.req_size),
    bus.req_addr[OFFSET_W-1:0]
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (mis_req)
            state_d = S_RESP;
          else if (bus.req_write &&
                   size_e'(bus.req_size) == SZ_D)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ:  state_d = write_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q  <= 1'b0;
      size_q   <= SZ_B;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cap_q    <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      if (accept) begin
        write_q  <= bus.req_write;
        size_q   <= size_e'(bus.req_size);
        signed_q <= bus.req_signed;
        addr_q   <= bus.req_addr[LADDR_W-1:0];
        wdata_q  <= bus.req_wdata;
        mis_q    <= mis_req;
        if (mis_req) rdata_q <= '0;
      end
      if (state_q == S_READ) begin
        if (write_q) cap_q   <= ram_out;
        else         rdata_q <= load_val;
      end
    end
  end

  lsu_lane_align u_align (
    .size_i   (size_q),
    .sgn_i    (signed_q),
    .offset_i (addr_q[OFFSET_W-1:0]),
    .rdata_i  (ram_out),
    .old_i    (cap_q),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .merge_o  (merged)
  );

  assign bus.req_ready       = (state_q == S_IDLE);
  assign bus.resp_valid      = (state_q == S_RESP);
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_misaligned = mis_q && bus.resp_valid;

  assign ram_address = addr_q[LADDR_W-1:OFFSET_W];
  assign ram_write   = (state_q == S_WRITE);
  assign ram_in      = ram_write ? merged : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Random and directed checks of load_store_unit against a
// byte-array memory model.
module tb_load_store_unit;

  logic        clock;
  logic        reset_n;
  logic [7:0]  ram_address;
  logic [63:0] ram_in;
  logic        ram_write;
  logic [63:0] ram_out;

  lsu_if bus ();

  load_store_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_write   (ram_write),
    .ram_out     (ram_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [63:0] ram [256];
  always @(negedge clock)
    if (ram_write) ram[ram_address] <= ram_in;
  assign ram_out = ram[ram_address];

  logic [7:0]  ref_mem [2048];
  logic [63:0] exp_rdata;
  int checks;
  int fails;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_wdata  = '0;
  endtask

  task automatic noise();
    bus.req_valid  = 1'($urandom_range(0, 1));
    bus.req_write  = 1'($urandom_range(0, 1));
    bus.req_addr   = {$urandom, $urandom};
    bus.req_size   = 2'($urandom_range(0, 3));
    bus.req_signed = 1'($urandom_range(0, 1));
    bus.req_wdata  = {$urandom, $urandom};
  endtask

  // Called #1 after a rising edge with the unit idle.
  task automatic do_req(logic w, logic [63:0] a,
                        logic [1:0] sz, logic sg,
                        logic [63:0] wd, logic nz);
    int n, off, base, lat, wrc, exp_lat, exp_wr;
    logic mis;
    logic [63:0] v;
    n    = 1 << sz;
    off  = int'(a[2:0]);
    base = int'(a[10:0]);
    mis  = (off % n) != 0;
    if (mis) begin
      exp_rdata = '0;
      exp_lat = 1;
      exp_wr  = 0;
    end else if (w) begin
      for (int i = 0; i < n; i++)
        ref_mem[base + i] = wd[8*i +: 8];
      exp_lat = (n == 8) ? 2 : 3;
      exp_wr  = 1;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++)
        v[8*i +: 8] = ref_mem[base + i];
      if (sg && n < 8 && v[8*n-1])
        v = v | ~((64'd1 << (8*n)) - 64'd1);
      exp_rdata = v;
      exp_lat = 2;
      exp_wr  = 0;
    end
    chk("ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_wdata  = wd;
    @(posedge clock);
    #1;
    idle_bus();
    chk("ram_addr", 64'(ram_address), 64'(a[10:3]));
    lat = 1;
    wrc = 0;
    while (1) begin
      if (ram_write) wrc++;
      if (bus.resp_valid) break;
      if (lat >= 8) break;
      if (nz) noise();
      @(posedge clock);
      #1;
      idle_bus();
      lat++;
    end
    chk("resp_seen", 64'(bus.resp_valid), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("wr_cycles", 64'(wrc), 64'(exp_wr));
    chk("misaligned", 64'(bus.resp_misaligned),
        64'(mis));
    chk("rdata", bus.resp_rdata, exp_rdata);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    int rc;
    checks = 0;
    fails  = 0;
    exp_rdata = '0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
    idle_bus();
    reset_n = 1'b0;
    #2;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rvalid", 64'(bus.resp_valid), 64'd0);
    chk("rst_rdata", bus.resp_rdata, 64'd0);
    chk("rst_mis", 64'(bus.resp_misaligned), 64'd0);
    chk("rst_raddr", 64'(ram_address), 64'd0);
    chk("rst_ramin", ram_in, 64'd0);
    chk("rst_ramwr", 64'(ram_write), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    do_req(1, 64'h18, 2'b11, 0,
           64'h1122334455667788, 0);
    do_req(0, 64'h18, 2'b11, 0, 0, 0);
    chk("d_load", bus.resp_rdata, 64'h1122334455667788);
    do_req(1, 64'h1D, 2'b00, 0,
           64'hFFFF_FFFF_FFFF_FFAB, 0);
    chk("d_mem3", ram[3], 64'h1122AB4455667788);
    do_req(0, 64'h1D, 2'b00, 1, 0, 0);
    chk("d_sb", bus.resp_rdata, 64'hFFFFFFFFFFFFFFAB);
    do_req(0, 64'h1D, 2'b00, 0, 0, 0);
    chk("d_ub", bus.resp_rdata, 64'h00000000000000AB);
    do_req(0, 64'h1A, 2'b10, 0, 0, 0);
    chk("d_misrd", bus.resp_rdata, 64'd0);
    do_req(0, 64'h818, 2'b11, 0, 0, 0);
    chk("d_alias", bus.resp_rdata, 64'h1122AB4455667788);

    // Half store aborted by reset while in WRITE.
    do_req(1, 64'h20, 2'b11, 0,
           64'hCAFE_F00D_1234_5678, 0);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = 64'h22;
    bus.req_size   = 2'b01;
    bus.req_wdata  = 64'hBEEF;
    @(posedge clock);
    #1;
    idle_bus();
    @(posedge clock);
    #1;
    chk("ab_wr_pre", 64'(ram_write), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("ab_wr", 64'(ram_write), 64'd0);
    chk("ab_rvalid", 64'(bus.resp_valid), 64'd0);
    chk("ab_ramin", ram_in, 64'd0);
    exp_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    rc = 0;
    repeat (4) begin
      @(posedge clock);
      #1;
      if (bus.resp_valid) rc++;
    end
    chk("ab_noresp", 64'(rc), 64'd0);
    chk("ab_ready", 64'(bus.req_ready), 64'd1);
    chk("ab_mem", ram[4], 64'hCAFE_F00D_1234_5678);

    for (int t = 0; t < 400; t++) begin
      a  = {$urandom, $urandom};
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a[10:6] = '0;
      if ($urandom_range(0, 3) != 0)
        a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
      do_req(1'($urandom_range(0, 1)), a, sz,
             1'($urandom_range(0, 1)),
             {$urandom, $urandom}, 1);
    end

    for (int i = 0; i < 256; i++) begin
      logic [63:0] v;
      for (int b = 0; b < 8; b++)
        v[8*b +: 8] = ref_mem[8*i + b];
      chk($sformatf("mem[%0d]", i), ram[i], v);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clock  in  1  system clock; the RAM stage samples on its falling edge.
REQ-002 reset_n  in  1  reset, asynchronous, active-low.
REQ-003 req_valid  in  1  memory request present.
REQ-004 req_ready  out  1  unit accepts a request; high only in IDLE.
REQ-005 req_write  in  1  1 = store, 0 = load.
REQ-006 req_addr  in  64  byte address.
REQ-007 req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 doubleword.
REQ-008 req_signed  in  1  sign-extend load result (LDURSW etc.).
REQ-009 req_wdata  in  64  store data, right-justified.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  64  load result, held until the next response.
REQ-012 resp_misaligned  out  1  error flag, valid with resp_valid.
REQ-013 ram_address  out  8  doubleword index to the 256x64 data RAM.
REQ-014 ram_in  out  64  RAM write data.
REQ-015 ram_write  out  1  RAM write enable.
REQ-016 ram_out  in  64  RAM read data, valid by the next rising edge after ram_address is stable.

Function
REQ-017 A request SHALL be accepted on a rising edge with req_valid && req_ready; all req_* fields SHALL be latched at acceptance.
REQ-018 ram_address SHALL be req_addr[10:3]; offset SHALL be req_addr[2:0]; bits [63:11] SHALL be ignored, so addresses wrap modulo 2048.
REQ-019 Misaligned means offset is not a multiple of the size (half: off[0]; word: off[1:0]; dword: off[2:0]).
REQ-020 The FSM SHALL have states IDLE, READ, WRITE and RESP.
REQ-021 IDLE -> RESP on a misaligned request; IDLE -> WRITE on an aligned dword store; otherwise IDLE -> READ.
REQ-022 READ (1 cycle) SHALL capture ram_out at its closing edge; loads SHALL go to RESP and stores to WRITE.
REQ-023 WRITE (1 cycle) SHALL drive ram_write=1 with ram_in = the merged doubleword, then go to RESP.
REQ-024 RESP (1 cycle) SHALL drive resp_valid=1 and then return to IDLE.
REQ-025 Latency from acceptance edge to resp_valid: load 2 cycles, sub-dword store 3, dword store 2, misaligned 1.
REQ-026 Byte lanes SHALL be little-endian: byte k occupies bits [8k+7:8k].
REQ-027 Load extract: the selected field SHALL be shifted to bit 0 and zero-extended, or sign-extended if req_signed; a dword load ignores req_signed.
REQ-028 Store merge: only the addressed bytes SHALL be replaced by the low bytes of req_wdata; other bytes SHALL keep their values from the READ capture.
REQ-029 A misaligned request SHALL make no RAM access (ram_write stays 0); resp_misaligned=1 and resp_rdata=0.
REQ-030 A store response SHALL leave resp_rdata unchanged, with resp_misaligned=0.
REQ-031 ram_write SHALL be 1 only in WRITE; ram_address SHALL be stable throughout READ and WRITE.
REQ-032 req_valid outside IDLE SHALL be ignored; no request queuing.

Reset
REQ-033 reset_n low SHALL immediately force: state IDLE, ram_write 0, resp_valid 0, resp_misaligned 0, resp_rdata 0, ram_address 0, ram_in 0.
REQ-034 Reset in READ or WRITE SHALL abort the operation with no response; a write not yet sampled by the RAM falling edge SHALL be lost.

Structure
REQ-035 Package lsu_pkg SHALL hold the size encodings, state enum, and constants RAM_AW=8 and OFFSET_W=3.
REQ-036 Sub-module lsu_lane_align (combinational extract/sign-extend and merge) SHALL be instantiated once.

Verification
REQ-037 Dword store 0x1122334455667788 @0x18, then dword load @0x18 -> ram_address 3, rdata 0x1122334455667788, load latency 2.
REQ-038 Byte store 0xAB @0x1D over the prior value -> mem[3]=0x1122AB4455667788; ram_write high exactly 1 cycle.
REQ-039 Signed byte load @0x1D -> 0xFFFFFFFFFFFFFFAB; unsigned -> 0x00000000000000AB.
REQ-040 Word load @0x1A -> resp_misaligned=1, rdata 0, no ram_write, latency 1.
REQ-041 Address 0x818 -> aliases to ram_address 3.
REQ-042 reset_n low during WRITE of a half store -> ram_write 0 immediately, no resp_valid, req_ready 1 after release.
